// File: rtl/lorenz_step_ctrl.sv
// Step sequencer for the fixed-point Lorenz solver: issues solver load/step strobes,
// paces steps with a programmable divider, counts steps against an optional limit and
// hands each new x/y/z state to a downstream consumer through a valid/ready register.
module lorenz_step_ctrl #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    reinit,
  input  logic [DIV_W-1:0]        div,
  input  logic [CNT_W-1:0]        max_steps,
  input  logic signed [26:0]      x_in,
  input  logic signed [26:0]      y_in,
  input  logic signed [26:0]      z_in,
  output logic                    solver_init,
  output logic                    step_en,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic signed [26:0]      sample_x,
  output logic signed [26:0]      sample_y,
  output logic signed [26:0]      sample_z,
  output logic [CNT_W-1:0]        step_count,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]    step_count_q, step_count_d;
  logic [CNT_W-1:0]    count_inc;
  logic                cap_pend_q, cap_pend_d;
  logic                sample_valid_q, sample_valid_d;
  logic signed [26:0]  sample_x_q, sample_x_d;
  logic signed [26:0]  sample_y_q, sample_y_d;
  logic signed [26:0]  sample_z_q, sample_z_d;
  logic                solver_init_q, busy_q, done_q;
  logic                outstanding;
  logic                step_fire;

  // Step decision: divider expired, no sample in flight, and no command overriding RUN.
  // A handshake in this cycle frees the register, so a step may coincide with it.
  always_comb begin
    outstanding = cap_pend_q | (sample_valid_q & ~sample_ready);
    step_fire   = (state_q == StRun) && !reinit && !stop && (div_cnt_q >= div) && !outstanding;
    count_inc   = step_count_q + CNT_W'(1);
  end

  // Sequencer next state, divider and step counter.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    step_count_d = step_count_q;
    if (reinit) begin
      state_d = StInit;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!stop && start) state_d = StInit;
        end
        StInit: begin
          state_d = stop ? StIdle : StRun;
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (step_fire) begin
            step_count_d = count_inc;
            div_cnt_d    = '0;
            if ((max_steps != '0) && (count_inc == max_steps)) state_d = StDone;
          end else if (div_cnt_q < div) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        StDone: begin
          if (stop)       state_d = StIdle;
          else if (start) state_d = StInit;
        end
        default: state_d = StIdle;
      endcase
    end
    // Clearing on entry makes step_count read 0 during the INIT cycle itself.
    if (state_d == StInit && state_q != StInit) begin
      div_cnt_d    = '0;
      step_count_d = '0;
    end
  end

  // Sample capture one cycle after each step; held until accepted, dropped only by reinit.
  always_comb begin
    cap_pend_d     = step_fire;
    sample_valid_d = sample_valid_q;
    sample_x_d     = sample_x_q;
    sample_y_d     = sample_y_q;
    sample_z_d     = sample_z_q;
    if (reinit) begin
      sample_valid_d = 1'b0;
    end else if (cap_pend_q) begin
      sample_x_d     = x_in;
      sample_y_d     = y_in;
      sample_z_d     = z_in;
      sample_valid_d = 1'b1;
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      div_cnt_q      <= '0;
      step_count_q   <= '0;
      cap_pend_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_x_q     <= '0;
      sample_y_q     <= '0;
      sample_z_q     <= '0;
      solver_init_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      div_cnt_q      <= div_cnt_d;
      step_count_q   <= step_count_d;
      cap_pend_q     <= cap_pend_d;
      sample_valid_q <= sample_valid_d;
      sample_x_q     <= sample_x_d;
      sample_y_q     <= sample_y_d;
      sample_z_q     <= sample_z_d;
      solver_init_q  <= (state_d == StInit);
      busy_q         <= (state_d == StInit) || (state_d == StRun);
      done_q         <= (state_d == StDone);
    end
  end

  assign solver_init  = solver_init_q;
  assign step_en      = step_fire;
  assign sample_valid = sample_valid_q;
  assign sample_x     = sample_x_q;
  assign sample_y     = sample_y_q;
  assign sample_z     = sample_z_q;
  assign step_count   = step_count_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_lorenz_step_ctrl.sv
// Directed bench for lorenz_step_ctrl, built with a 4-bit step counter so wrap is reachable.
module tb_lorenz_step_ctrl;

  localparam int unsigned DIV_W = 16;
  localparam int unsigned CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0, stop = 1'b0, reinit = 1'b0;
  logic [DIV_W-1:0]    div = '0;
  logic [CNT_W-1:0]    max_steps = '0;
  logic signed [26:0]  x_in = '0, y_in = '0, z_in = '0;
  logic                solver_init, step_en, sample_valid;
  logic                sample_ready = 1'b0;
  logic signed [26:0]  sample_x, sample_y, sample_z;
  logic [CNT_W-1:0]    step_count;
  logic                busy, done;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  lorenz_step_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .reinit       (reinit),
    .div          (div),
    .max_steps    (max_steps),
    .x_in         (x_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .solver_init  (solver_init),
    .step_en      (step_en),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .step_count   (step_count),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic e_init;
    logic e_step;
    logic e_valid;
    logic e_busy;
    logic e_done;
    int   e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic s, input logic ei, input logic es, input logic ev,
                     input logic eb, input logic ed, input int ec);
    vec_t v;
    v.start = s; v.e_init = ei; v.e_step = es; v.e_valid = ev;
    v.e_busy = eb; v.e_done = ed; v.e_cnt = ec;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance to 2 time units after the next rising edge; solver outputs change per cycle.
  task automatic next_cycle();
    @(posedge clk);
    #2;
    cyc++;
    x_in = 27'(cyc * 3 + 5);
    y_in = 27'(cyc * 7 + 1);
    z_in = -27'(cyc);
  endtask

  task automatic do_reset();
    start = 0; stop = 0; reinit = 0; sample_ready = 0;
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  logic signed [26:0] prev_x, held_x, held_y;
  int steps, cnt_m;

  initial begin
    // Reset values.
    do_reset();
    #1;
    chk("rst_init", 64'(solver_init), 64'(0));
    chk("rst_step", 64'(step_en), 64'(0));
    chk("rst_valid", 64'(sample_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_cnt", 64'(step_count), 64'(0));
    chk("rst_sx", 64'(sample_x), 64'(0));

    // Test 1: div=3, max_steps=4, ready=1; start in row 0.
    //   start init step valid busy done cnt
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 1, 1, 0, 2);
    add(0, 0, 0, 0, 1, 0, 2);
    add(0, 0, 1, 0, 1, 0, 2);
    add(0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 1, 0, 3);
    add(0, 0, 1, 0, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 4);
    add(0, 0, 0, 1, 0, 1, 4);
    add(0, 0, 0, 0, 0, 1, 4);

    div = 16'd3; max_steps = 4'd4; sample_ready = 1;
    prev_x = x_in;
    for (int i = 0; i < tbl.size(); i++) begin
      next_cycle();
      start = tbl[i].start;
      #1;
      chk("t1_init", 64'(solver_init), 64'(tbl[i].e_init));
      chk("t1_step", 64'(step_en), 64'(tbl[i].e_step));
      chk("t1_valid", 64'(sample_valid), 64'(tbl[i].e_valid));
      chk("t1_busy", 64'(busy), 64'(tbl[i].e_busy));
      chk("t1_done", 64'(done), 64'(tbl[i].e_done));
      chk("t1_cnt", 64'(step_count), 64'(tbl[i].e_cnt));
      if (tbl[i].e_valid) chk("t1_sx", 64'(sample_x), 64'(prev_x));
      prev_x = x_in;
    end

    // Test 2: free-run, div=0, ready=1; step every 2 cycles and count wraps 15 -> 0.
    do_reset();
    div = '0; max_steps = '0; sample_ready = 1;
    cnt_m = 0;
    for (int k = 0; k < 40; k++) begin
      next_cycle();
      start = (k == 0);
      #1;
      chk("t2_step", 64'(step_en), 64'((k >= 2) && ((k % 2) == 0)));
      chk("t2_cnt", 64'(step_count), 64'(cnt_m));
      if (k == 33) chk("t2_wrap", 64'(step_count), 64'(0));
      if (step_en) cnt_m = (cnt_m + 1) % 16;
    end

    // Test 3: backpressure with ready low for 20 cycles, div=0.
    do_reset();
    div = '0; max_steps = '0; sample_ready = 0;
    steps = 0;
    for (int k = 0; k < 22; k++) begin
      next_cycle();
      start = (k == 0);
      #1;
      if (step_en) steps++;
      if (k == 3) begin held_x = x_in; held_y = y_in; end
      if (k >= 4) begin
        chk("t3_valid", 64'(sample_valid), 64'(1));
        chk("t3_sx", 64'(sample_x), 64'(held_x));
      end
    end
    chk("t3_steps", 64'(steps), 64'(1));
    chk("t3_sy", 64'(sample_y), 64'(held_y));
    next_cycle();
    sample_ready = 1;
    #1;
    chk("t3_resume", 64'(step_en), 64'(1));
    next_cycle();
    #1;
    chk("t3_cnt", 64'(step_count), 64'(2));
    chk("t3_consumed", 64'(sample_valid), 64'(0));

    // Test 4: stop the cycle after a step; pending sample survives into IDLE.
    do_reset();
    div = 16'd2; max_steps = '0; sample_ready = 0;
    for (int k = 0; k < 11; k++) begin
      next_cycle();
      start = (k == 0);
      stop  = (k == 5);
      sample_ready = (k == 9);
      #1;
      if (k == 4) chk("t4_step", 64'(step_en), 64'(1));
      if (k == 5) begin
        chk("t4_busy_run", 64'(busy), 64'(1));
        held_x = x_in;
      end
      if (k >= 6) begin
        chk("t4_busy", 64'(busy), 64'(0));
        chk("t4_cnt", 64'(step_count), 64'(1));
        chk("t4_nostep", 64'(step_en), 64'(0));
      end
      if (k >= 6 && k <= 9) begin
        chk("t4_valid", 64'(sample_valid), 64'(1));
        chk("t4_sx", 64'(sample_x), 64'(held_x));
      end
      if (k == 10) chk("t4_accepted", 64'(sample_valid), 64'(0));
    end
    stop = 0; sample_ready = 0;

    // Test 5: reinit while a sample is held in RUN.
    do_reset();
    div = 16'd2; max_steps = '0; sample_ready = 0;
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      start  = (k == 0);
      reinit = (k == 7);
      #1;
      if (k == 4) chk("t5_step", 64'(step_en), 64'(1));
      if (k == 7) chk("t5_valid_pre", 64'(sample_valid), 64'(1));
      if (k == 8) begin
        chk("t5_init", 64'(solver_init), 64'(1));
        chk("t5_valid_clr", 64'(sample_valid), 64'(0));
        chk("t5_cnt", 64'(step_count), 64'(0));
      end
      if (k == 9 || k == 10) chk("t5_wait", 64'(step_en), 64'(0));
      if (k == 11) chk("t5_first", 64'(step_en), 64'(1));
    end
    reinit = 0;

    // Test 6: all commands together in IDLE, then async reset mid-cycle in RUN.
    do_reset();
    div = '0; max_steps = '0; sample_ready = 0;
    next_cycle();
    start = 1; stop = 1; reinit = 1;
    next_cycle();
    start = 0; stop = 0; reinit = 0;
    #1;
    chk("t6_init", 64'(solver_init), 64'(1));
    next_cycle();
    #1;
    chk("t6_step", 64'(step_en), 64'(1));
    next_cycle();
    next_cycle();
    #1;
    chk("t6_valid", 64'(sample_valid), 64'(1));
    next_cycle();
    reset = 1;
    #1;
    chk("t6_r_valid", 64'(sample_valid), 64'(0));
    chk("t6_r_sx", 64'(sample_x), 64'(0));
    chk("t6_r_busy", 64'(busy), 64'(0));
    chk("t6_r_cnt", 64'(step_count), 64'(0));
    chk("t6_r_step", 64'(step_en), 64'(0));
    chk("t6_r_init", 64'(solver_init), 64'(0));
    chk("t6_r_done", 64'(done), 64'(0));
    next_cycle();
    reset = 0;
    next_cycle();
    #1;
    chk("t6_idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
